// File: rtl/mfp_ahb_lite_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mfp_ahb_lite_master_pkg
// Description : Shared AHB-Lite encodings and the response record used by the
//               mfp_ahb_lite_master initiator and its response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package mfp_ahb_lite_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int RSP_W = 33;

    // Response FIFO entry: error flag above the 32-bit read data.
    typedef struct packed {
        logic        error;
        logic [31:0] rdata;
    } rsp_t;

    // Writes and errored transfers never return bus data to the requester.
    function automatic rsp_t make_rsp(input logic        is_write,
                                      input logic        err,
                                      input logic [31:0] rdata);
        rsp_t r;
        r.error = err;
        r.rdata = (is_write | err) ? 32'h0 : rdata;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mfp_ahb_lite_master_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mfp_ahb_lite_master_rsp_fifo
// Description : Synchronous response FIFO, DEPTH entries of WIDTH bits.
//               A push and a pop in the same cycle are both performed.
// Ports       : clk_i/rst_ni  clock, async active-low reset
//               push_i/wdata_i write side
//               pop_i/rdata_o  read side (rdata_o shows the head entry)
//               empty_o/count_o occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module mfp_ahb_lite_master_rsp_fifo
    import mfp_ahb_lite_master_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = RSP_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign w_do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_do_push = push_i & (~w_full | w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (w_do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mfp_ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : mfp_ahb_lite_master
// Description : AHB-Lite initiator turning a valid/ready request stream into
//               pipelined SINGLE transfers, with in-order responses through
//               an internal FIFO.
// Ports       : HCLK/HRESETn           clock, async active-low reset
//               req_*                  request channel (req_ready is comb.)
//               rsp_*                  response channel (FIFO head)
//               H* outputs             registered AHB-Lite master signals
//               HRDATA/HREADY/HRESP    AHB-Lite slave response
// Revision    : 1.0 - initial release
// ============================================================================
module mfp_ahb_lite_master
    import mfp_ahb_lite_master_pkg::*;
#(
    parameter int         RSP_DEPTH = 4,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic             addr_pending_q, addr_pending_d;
    logic             dp_pending_q,   dp_pending_d;
    logic             dp_write_q,     dp_write_d;
    logic [31:0]      wdata_q,        wdata_d;
    logic [CNT_W-1:0] outstanding_q,  outstanding_d;
    logic [1:0]       htrans_q,       htrans_d;
    logic [31:0]      haddr_q,        haddr_d;
    logic             hwrite_q,       hwrite_d;
    logic [2:0]       hsize_q,        hsize_d;
    logic [31:0]      hwdata_q,       hwdata_d;

    logic             w_accept;
    logic             w_addr_end;
    logic             w_dp_end;
    logic             w_rsp_pop;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    rsp_t             w_push_rsp;
    rsp_t             w_head_rsp;

    assign rsp_valid  = ~w_fifo_empty;
    assign w_rsp_pop  = rsp_valid & rsp_ready;
    // The outstanding count reserves a FIFO slot for every accepted request,
    // so the data phase never has to be stalled for lack of space.
    assign req_ready  = (~addr_pending_q | HREADY)
                      & ((outstanding_q < CNT_W'(RSP_DEPTH)) | w_rsp_pop);
    assign w_accept   = req_valid & req_ready;
    assign w_addr_end = addr_pending_q & HREADY;
    assign w_dp_end   = dp_pending_q & HREADY;
    assign w_push_rsp = make_rsp(dp_write_q, HRESP, HRDATA);

    always_comb begin
        addr_pending_d = addr_pending_q;
        dp_pending_d   = dp_pending_q;
        dp_write_d     = dp_write_q;
        wdata_d        = wdata_q;
        outstanding_d  = outstanding_q;
        htrans_d       = htrans_q;
        haddr_d        = haddr_q;
        hwrite_d       = hwrite_q;
        hsize_d        = hsize_q;
        hwdata_d       = hwdata_q;

        // Address phase: a new request may replace the one whose address
        // phase completes on this edge.
        if (w_accept) begin
            htrans_d       = HTRANS_NONSEQ;
            haddr_d        = req_addr;
            hwrite_d       = req_write;
            hsize_d        = req_size;
            wdata_d        = req_wdata;
            addr_pending_d = 1'b1;
        end else if (w_addr_end) begin
            htrans_d       = HTRANS_IDLE;
            addr_pending_d = 1'b0;
        end

        // Data phase: entered when an address phase completes, else left
        // when the current data phase completes.
        if (w_addr_end) begin
            dp_pending_d = 1'b1;
            dp_write_d   = hwrite_q;
            if (hwrite_q) begin
                hwdata_d = wdata_q;
            end
        end else if (w_dp_end) begin
            dp_pending_d = 1'b0;
        end

        case ({w_accept, w_rsp_pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_pending_q <= 1'b0;
            dp_pending_q   <= 1'b0;
            dp_write_q     <= 1'b0;
            wdata_q        <= 32'h0;
            outstanding_q  <= '0;
            htrans_q       <= HTRANS_IDLE;
            haddr_q        <= 32'h0;
            hwrite_q       <= 1'b0;
            hsize_q        <= 3'b000;
            hwdata_q       <= 32'h0;
        end else begin
            addr_pending_q <= addr_pending_d;
            dp_pending_q   <= dp_pending_d;
            dp_write_q     <= dp_write_d;
            wdata_q        <= wdata_d;
            outstanding_q  <= outstanding_d;
            htrans_q       <= htrans_d;
            haddr_q        <= haddr_d;
            hwrite_q       <= hwrite_d;
            hsize_q        <= hsize_d;
            hwdata_q       <= hwdata_d;
        end
    end

    mfp_ahb_lite_master_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (w_dp_end),
        .wdata_i (w_push_rsp),
        .pop_i   (w_rsp_pop),
        .rdata_o (w_head_rsp),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // Every queued response belongs to a still-counted request.
    a_fifo_within_outstanding : assert property (
        @(posedge HCLK) disable iff (!HRESETn) (w_fifo_count <= outstanding_q)
    );

    assign rsp_rdata = w_head_rsp.rdata;
    assign rsp_error = w_head_rsp.error;

    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mfp_ahb_lite_master
// Description : Directed self-checking bench for mfp_ahb_lite_master with a
//               small AHB-Lite RAM slave that can insert waits and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mfp_ahb_lite_master;
    import mfp_ahb_lite_master_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_lite_master #(.RSP_DEPTH(4), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // ---------------- slave model: word RAM, mem[k] = C0DE_0000 + k after reset
    logic [31:0] mem [256];
    logic        s_dp_valid;
    logic        s_dp_write;
    logic [31:0] s_dp_addr;
    int          s_dp_cyc;
    logic [31:0] wait_addr = 32'hFFFF_FFFF;
    int          wait_n = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
        if (s_dp_valid) begin
            HRDATA = mem[s_dp_addr[9:2]];
            if (s_dp_addr == err_addr) begin
                HRESP  = 1'b1;
                HREADY = (s_dp_cyc != 0);
            end else if (s_dp_addr == wait_addr && s_dp_cyc < wait_n) begin
                HREADY = 1'b0;
            end
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_dp_valid <= 1'b0;
            s_dp_write <= 1'b0;
            s_dp_addr  <= 32'h0;
            s_dp_cyc   <= 0;
            for (int k = 0; k < 256; k++) mem[k] <= 32'hC0DE_0000 + k;
        end else if (HREADY) begin
            if (s_dp_valid && s_dp_write && !HRESP) mem[s_dp_addr[9:2]] <= HWDATA;
            s_dp_valid <= (HTRANS == HTRANS_NONSEQ);
            s_dp_addr  <= HADDR;
            s_dp_write <= HWRITE;
            s_dp_cyc   <= 0;
        end else begin
            s_dp_cyc <= s_dp_cyc + 1;
        end
    end

    // ---------------- monitor: records just before each rising edge
    int          cyc = 0;
    int          rsp_cyc[$];
    logic [31:0] rsp_data[$];
    logic        rsp_err[$];
    int          ns_cyc[$];
    logic [31:0] wd_q[$];
    logic [31:0] wt_addr[$];
    logic [31:0] wt_wdata[$];
    logic [1:0]  wt_trans[$];

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        #4;
        if (HRESETn) begin
            if (rsp_valid && rsp_ready) begin
                rsp_cyc.push_back(cyc);
                rsp_data.push_back(rsp_rdata);
                rsp_err.push_back(rsp_error);
            end
            if (HTRANS == HTRANS_NONSEQ) ns_cyc.push_back(cyc);
            if (s_dp_valid && s_dp_write && HREADY) wd_q.push_back(HWDATA);
            if (s_dp_valid && !HREADY) begin
                wt_addr.push_back(HADDR);
                wt_wdata.push_back(HWDATA);
                wt_trans.push_back(HTRANS);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers (stimulus only)
    task automatic clear_q();
        rsp_cyc.delete(); rsp_data.delete(); rsp_err.delete();
        ns_cyc.delete(); wd_q.delete();
        wt_addr.delete(); wt_wdata.delete(); wt_trans.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, output int acc_cyc);
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_size = HSIZE_WORD; req_wdata = wd;
        acc_cyc = -1;
        for (int t = 0; t < 100 && acc_cyc < 0; t++) begin
            #4;
            if (req_ready) acc_cyc = cyc;
            @(negedge HCLK);
        end
        if (acc_cyc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout addr=%h: got no accept, required accept", addr);
        end
    endtask

    task automatic wait_rsp(input int n);
        for (int t = 0; t < 200 && rsp_data.size() < n; t++) @(negedge HCLK);
        n_cmp++;
        if (rsp_data.size() < n) begin
            n_bad++;
            $display("FAIL rsp_count: got %0d required %0d", rsp_data.size(), n);
        end
    endtask

    // ---------------- tests
    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        n_cmp++;
        if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA} !== {2'b00, 32'h0, 1'b0, 3'b000, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_bus: got %h required %h",
                     {HTRANS, HADDR, HWRITE, HSIZE, HWDATA}, {2'b00, 32'h0, 1'b0, 3'b000, 32'h0});
        end
        n_cmp++;
        if ({HBURST, HMASTLOCK, HPROT} !== {3'b000, 1'b0, 4'b0011}) begin
            n_bad++;
            $display("FAIL reset_const: got %h required %h", {HBURST, HMASTLOCK, HPROT}, 8'h03);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
        @(negedge HCLK);
    endtask

    task automatic test_write_read();
        int a0, a1;
        clear_q(); rsp_ready = 1'b1;
        issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, a0);
        issue(1'b0, 32'h8000_0010, 32'h0, a1);
        req_valid = 1'b0;
        wait_rsp(2);
        repeat (2) @(negedge HCLK);
        n_cmp++;
        if (a1 - a0 !== 1) begin
            n_bad++; $display("FAIL wr_accept_gap: got %0d required 1", a1 - a0);
        end
        n_cmp++;
        if (rsp_cyc[0] - a0 !== 3) begin
            n_bad++; $display("FAIL wr_latency: got %0d required 3", rsp_cyc[0] - a0);
        end
        n_cmp++;
        if (ns_cyc.size() !== 2) begin
            n_bad++; $display("FAIL wr_nonseq_cycles: got %0d required 2", ns_cyc.size());
        end
        n_cmp++;
        if (wd_q.size() !== 1 || wd_q[0] !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL wr_hwdata: got %h required deadbeef", wd_q[0]);
        end
        n_cmp++;
        if ({rsp_err[0], rsp_data[0]} !== {1'b0, 32'h0}) begin
            n_bad++; $display("FAIL wr_rsp: got %b/%h required 0/00000000", rsp_err[0], rsp_data[0]);
        end
        n_cmp++;
        if ({rsp_err[1], rsp_data[1]} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL rd_rsp: got %b/%h required 0/deadbeef", rsp_err[1], rsp_data[1]);
        end
    endtask

    task automatic test_back_to_back();
        int acc[8];
        clear_q(); rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) issue(1'b0, 32'h8000_0100 + 4 * i, 32'h0, acc[i]);
        req_valid = 1'b0;
        wait_rsp(8);
        repeat (2) @(negedge HCLK);
        n_cmp++;
        if (acc[7] - acc[0] !== 7) begin
            n_bad++; $display("FAIL b2b_accept_span: got %0d required 7", acc[7] - acc[0]);
        end
        n_cmp++;
        if (ns_cyc.size() !== 8 || ns_cyc[7] - ns_cyc[0] !== 7) begin
            n_bad++; $display("FAIL b2b_nonseq: got %0d cycles required 8 consecutive", ns_cyc.size());
        end
        n_cmp++;
        if (rsp_cyc[7] - rsp_cyc[0] !== 7) begin
            n_bad++; $display("FAIL b2b_rsp_span: got %0d required 7", rsp_cyc[7] - rsp_cyc[0]);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({rsp_err[i], rsp_data[i]} !== {1'b0, 32'hC0DE_0040 + i}) begin
                n_bad++;
                $display("FAIL b2b_rdata[%0d]: got %b/%h required 0/%h", i, rsp_err[i], rsp_data[i],
                         32'hC0DE_0040 + i);
            end
        end
    endtask

    task automatic test_wait_states();
        int a, b, c;
        logic [31:0] exp_rd [3];
        exp_rd[0] = 32'h1111_1111; exp_rd[1] = 32'h2222_2222; exp_rd[2] = 32'h3333_3333;
        clear_q(); rsp_ready = 1'b1;
        wait_addr = 32'h8000_0024; wait_n = 3;
        issue(1'b1, 32'h8000_0020, 32'h1111_1111, a);
        issue(1'b1, 32'h8000_0024, 32'h2222_2222, b);
        issue(1'b1, 32'h8000_0028, 32'h3333_3333, c);
        req_valid = 1'b0;
        wait_rsp(3);
        wait_n = 0;
        repeat (2) @(negedge HCLK);
        n_cmp++;
        if (wt_addr.size() !== 3) begin
            n_bad++; $display("FAIL wait_cycles: got %0d required 3", wt_addr.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({wt_trans[i], wt_addr[i], wt_wdata[i]} !== {HTRANS_NONSEQ, 32'h8000_0028, 32'h2222_2222}) begin
                n_bad++;
                $display("FAIL wait_hold[%0d]: got %h/%h/%h required 2/80000028/22222222",
                         i, wt_trans[i], wt_addr[i], wt_wdata[i]);
            end
        end
        n_cmp++;
        if (rsp_cyc[1] - rsp_cyc[0] !== 4 || rsp_cyc[2] - rsp_cyc[1] !== 1) begin
            n_bad++;
            $display("FAIL wait_rsp_timing: got gaps %0d,%0d required 4,1",
                     rsp_cyc[1] - rsp_cyc[0], rsp_cyc[2] - rsp_cyc[1]);
        end
        n_cmp++;
        if (wd_q.size() !== 3 || {wd_q[0], wd_q[1], wd_q[2]} !==
            {32'h1111_1111, 32'h2222_2222, 32'h3333_3333}) begin
            n_bad++; $display("FAIL wait_wdata_order: got %h %h %h", wd_q[0], wd_q[1], wd_q[2]);
        end
        clear_q();
        issue(1'b0, 32'h8000_0020, 32'h0, a);
        issue(1'b0, 32'h8000_0024, 32'h0, b);
        issue(1'b0, 32'h8000_0028, 32'h0, c);
        req_valid = 1'b0;
        wait_rsp(3);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rsp_data[i] !== exp_rd[i]) begin
                n_bad++; $display("FAIL wait_readback[%0d]: got %h required %h", i, rsp_data[i], exp_rd[i]);
            end
        end
        repeat (2) @(negedge HCLK);
    endtask

    task automatic test_error();
        int a, b;
        clear_q(); rsp_ready = 1'b1;
        err_addr = 32'hBF80_0100;
        issue(1'b0, 32'hBF80_0100, 32'h0, a);
        issue(1'b0, 32'h8000_0010, 32'h0, b);
        req_valid = 1'b0;
        wait_rsp(2);
        err_addr = 32'hFFFF_FFFF;
        repeat (2) @(negedge HCLK);
        n_cmp++;
        if ({rsp_err[0], rsp_data[0]} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL err_rsp: got %b/%h required 1/00000000", rsp_err[0], rsp_data[0]);
        end
        n_cmp++;
        if ({rsp_err[1], rsp_data[1]} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL err_next_rsp: got %b/%h required 0/deadbeef", rsp_err[1], rsp_data[1]);
        end
        n_cmp++;
        if (rsp_cyc[0] - a !== 4) begin
            n_bad++; $display("FAIL err_latency: got %0d required 4", rsp_cyc[0] - a);
        end
        n_cmp++;
        if (wt_addr.size() !== 1 || {wt_trans[0], wt_addr[0]} !== {HTRANS_NONSEQ, 32'h8000_0010}) begin
            n_bad++;
            $display("FAIL err_addr_hold: got %0d cycles %h/%h required 1 cycle 2/80000010",
                     wt_addr.size(), wt_trans[0], wt_addr[0]);
        end
    endtask

    task automatic test_backpressure();
        int acc[6];
        logic stuck_ready;
        clear_q(); rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'h8000_0100 + 4 * i, 32'h0, acc[i]);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0110;
        stuck_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            #4;
            if (req_ready) stuck_ready = 1'b1;
            @(negedge HCLK);
        end
        n_cmp++;
        if (acc[3] - acc[0] !== 3) begin
            n_bad++; $display("FAIL bp_accept_span: got %0d required 3", acc[3] - acc[0]);
        end
        n_cmp++;
        if (stuck_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_req_ready: got 1 required 0 after 4 accepts");
        end
        n_cmp++;
        if ({HTRANS, rsp_valid} !== {HTRANS_IDLE, 1'b1}) begin
            n_bad++; $display("FAIL bp_bus_idle: got %h/%b required 0/1", HTRANS, rsp_valid);
        end
        rsp_ready = 1'b1;
        issue(1'b0, 32'h8000_0110, 32'h0, acc[4]);
        issue(1'b0, 32'h8000_0114, 32'h0, acc[5]);
        req_valid = 1'b0;
        wait_rsp(6);
        repeat (2) @(negedge HCLK);
        n_cmp++;
        if (rsp_cyc[3] - rsp_cyc[0] !== 3) begin
            n_bad++; $display("FAIL bp_drain: got %0d required 3", rsp_cyc[3] - rsp_cyc[0]);
        end
        n_cmp++;
        if (acc[4] !== rsp_cyc[0] || acc[5] - acc[4] !== 1) begin
            n_bad++;
            $display("FAIL bp_resume: got accept %0d,%0d required %0d,%0d",
                     acc[4], acc[5], rsp_cyc[0], rsp_cyc[0] + 1);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (rsp_data[i] !== 32'hC0DE_0040 + i) begin
                n_bad++; $display("FAIL bp_rdata[%0d]: got %h required %h", i, rsp_data[i], 32'hC0DE_0040 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc[3];
        int a;
        clear_q(); rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b0, 32'h8000_0100 + 4 * i, 32'h0, acc[i]);
        req_valid = 1'b0;
        #1;
        n_cmp++;
        if ({HTRANS, rsp_valid} !== {HTRANS_NONSEQ, 1'b1}) begin
            n_bad++; $display("FAIL rstmid_pre: got %h/%b required 2/1", HTRANS, rsp_valid);
        end
        HRESETn = 1'b0;
        #1;
        n_cmp++;
        if ({HTRANS, rsp_valid} !== {HTRANS_IDLE, 1'b0}) begin
            n_bad++; $display("FAIL rstmid_async: got %h/%b required 0/0", HTRANS, rsp_valid);
        end
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        clear_q(); rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_req_ready: got %b required 1", req_ready);
        end
        @(negedge HCLK);
        issue(1'b0, 32'h8000_0010, 32'h0, a);
        req_valid = 1'b0;
        wait_rsp(1);
        repeat (4) @(negedge HCLK);
        n_cmp++;
        if (rsp_data.size() !== 1 || {rsp_err[0], rsp_data[0]} !== {1'b0, 32'hC0DE_0004}) begin
            n_bad++;
            $display("FAIL rstmid_read: got %0d rsp %b/%h required 1 rsp 0/c0de0004",
                     rsp_data.size(), rsp_err[0], rsp_data[0]);
        end
        n_cmp++;
        if (rsp_cyc[0] - a !== 3) begin
            n_bad++; $display("FAIL rstmid_latency: got %0d required 3", rsp_cyc[0] - a);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
